// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO registers.
// Results wait in a buffer and reach HI/LO only when the owning instruction
// leaves EX. A flush therefore never alters architectural state.
module mdu_hilo #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_ITERS  = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [2:0]  ex_mdu_op,
    input  logic [31:0] ex_src_a,
    input  logic [31:0] ex_src_b,
    input  logic        ex_leave,
    input  logic        flush,
    output logic        div_mul_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

    state_t state, state_nxt;
    logic [5:0] cnt_p0;
    logic       op_is_mul, op_is_div, mul_signed, div_signed, issue;

    logic [31:0] dvs_p0, quo_p0, rem_p0, src_a_p0;
    logic        q_neg_p0, r_neg_p0, dvs_zero_p0;
    logic [63:0] res_p1;

    logic signed [63:0] mul_a, mul_b, mul_full;
    logic [32:0] div_shift, div_trial;
    logic [31:0] rem_nxt, quo_nxt;

    // Two's-complement magnitude; 0x80000000 maps onto itself as an unsigned value.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    // Sign fixup of the magnitude quotient/remainder, plus the divide-by-zero result.
    function automatic logic [63:0] div_fixup(input logic [31:0] quo, input logic [31:0] rem,
                                              input logic q_neg, input logic r_neg,
                                              input logic dvs_zero, input logic [31:0] src_a);
        logic [31:0] q;
        logic [31:0] r;
        q = q_neg ? (~quo + 32'd1) : quo;
        r = r_neg ? (~rem + 32'd1) : rem;
        if (dvs_zero) begin
            q = 32'hFFFF_FFFF;
            r = src_a;
        end
        return {r, q};
    endfunction

    // Issue detection, stall generation and status.
    always_comb begin
        op_is_mul     = (ex_mdu_op == 3'd1) || (ex_mdu_op == 3'd2);
        op_is_div     = (ex_mdu_op == 3'd3) || (ex_mdu_op == 3'd4);
        mul_signed    = (ex_mdu_op == 3'd1);
        div_signed    = (ex_mdu_op == 3'd3);
        issue         = resetn && (state == S_IDLE) && ex_valid && (op_is_mul || op_is_div) && !flush;
        busy          = (state == S_MUL) || (state == S_DIV);
        div_mul_stall = issue || (resetn && !flush && busy);
    end

    // Full 64-bit product from sign- or zero-extended operands, taken in the issue cycle.
    always_comb begin
        mul_a    = {{32{mul_signed & ex_src_a[31]}}, ex_src_a};
        mul_b    = {{32{mul_signed & ex_src_b[31]}}, ex_src_b};
        mul_full = mul_a * mul_b;
    end

    // One restoring-division step on the operand magnitudes.
    always_comb begin
        div_shift = {rem_p0, quo_p0[31]};
        div_trial = div_shift - {1'b0, dvs_p0};
        rem_nxt   = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
        quo_nxt   = {quo_p0[30:0], ~div_trial[32]};
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (issue) state_nxt = op_is_div ? S_DIV : ((MUL_CYCLES == 1) ? S_DONE : S_MUL);
                S_MUL:  if (cnt_p0 == MUL_LAST) state_nxt = S_DONE;
                S_DIV:  if (cnt_p0 == DIV_LAST) state_nxt = S_DONE;
                S_DONE: if (ex_leave) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register and cycle counter (the issue cycle is multiply cycle 1).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            cnt_p0 <= 6'd0;
        end else begin
            state <= state_nxt;
            if (issue)
                cnt_p0 <= op_is_mul ? 6'd1 : 6'd0;
            else if (busy)
                cnt_p0 <= cnt_p0 + 6'd1;
        end
    end

    // Operand latch at issue, divide iterations, result buffer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvs_p0      <= '0;
            quo_p0      <= '0;
            rem_p0      <= '0;
            src_a_p0    <= '0;
            q_neg_p0    <= 1'b0;
            r_neg_p0    <= 1'b0;
            dvs_zero_p0 <= 1'b0;
            res_p1      <= '0;
        end else if (issue) begin
            dvs_p0      <= magnitude(ex_src_b, div_signed);
            quo_p0      <= magnitude(ex_src_a, div_signed);
            rem_p0      <= '0;
            src_a_p0    <= ex_src_a;
            q_neg_p0    <= div_signed & (ex_src_a[31] ^ ex_src_b[31]);
            r_neg_p0    <= div_signed & ex_src_a[31];
            dvs_zero_p0 <= (ex_src_b == 32'd0);
            res_p1      <= op_is_mul ? mul_full : 64'd0;
        end else if ((state == S_DIV) && !flush) begin
            rem_p0 <= rem_nxt;
            quo_p0 <= quo_nxt;
            if (cnt_p0 == DIV_LAST)
                res_p1 <= div_fixup(quo_nxt, rem_nxt, q_neg_p0, r_neg_p0, dvs_zero_p0, src_a_p0);
        end
    end

    // Architectural HI/LO: buffered commit on leave, or direct MTHI/MTLO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (!flush && ex_leave) begin
            if (state == S_DONE) begin
                hi <= res_p1[63:32];
                lo <= res_p1[31:0];
            end else if ((state == S_IDLE) && ex_valid) begin
                if (ex_mdu_op == 3'd5) hi <= ex_src_a;
                if (ex_mdu_op == 3'd6) lo <= ex_src_a;
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed testbench for mdu_hilo: one task per scenario with inline checks.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid;
    logic [2:0]  ex_mdu_op;
    logic [31:0] ex_src_a;
    logic [31:0] ex_src_b;
    logic        ex_leave;
    logic        flush;
    logic        div_mul_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mdu_hilo #(.MUL_CYCLES(2), .DIV_ITERS(32)) dut (
        .clk(clk), .resetn(resetn), .ex_valid(ex_valid), .ex_mdu_op(ex_mdu_op),
        .ex_src_a(ex_src_a), .ex_src_b(ex_src_b), .ex_leave(ex_leave), .flush(flush),
        .div_mul_stall(div_mul_stall), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    // Present an op and count stall cycles until the stall drops (bounded).
    // Sources are scrambled after the issue edge to show they were latched.
    task automatic start_and_wait(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output int n);
        ex_valid = 1'b1; ex_mdu_op = op; ex_src_a = a; ex_src_b = b;
        ex_leave = 1'b0; flush = 1'b0;
        n = 0;
        #1;
        while (div_mul_stall === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
            ex_src_a = ~a;
            ex_src_b = b ^ 32'h5A5A_0001;
            #1;
        end
    endtask

    // Let the instruction leave EX for one edge, then empty EX.
    task automatic leave_ex();
        ex_leave = 1'b1;
        @(posedge clk); #1;
        ex_leave = 1'b0; ex_valid = 1'b0; ex_mdu_op = 3'd0;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; ex_valid = 1'b0; ex_mdu_op = 3'd0; ex_src_a = '0; ex_src_b = '0;
        ex_leave = 1'b0; flush = 1'b0;
        #2;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || div_mul_stall !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: hi=%h lo=%h stall=%b busy=%b expected all zero", hi, lo, div_mul_stall, busy);
        end
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_mthi_mtlo();
        ex_valid = 1'b1; ex_mdu_op = 3'd5; ex_src_a = 32'hDEAD_BEEF; ex_leave = 1'b1;
        #1;
        checks++;
        if (div_mul_stall !== 1'b0) begin
            errors++;
            $display("FAIL mthi_stall: got %b expected 0", div_mul_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mthi_hi: got %h expected deadbeef", hi);
        end
        ex_mdu_op = 3'd6; ex_src_a = 32'h1357_9BDF;
        @(posedge clk); #1;
        checks++;
        if (lo !== 32'h1357_9BDF || hi !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h expected deadbeef 13579bdf", hi, lo);
        end
        // Without ex_leave the move must not write.
        ex_mdu_op = 3'd5; ex_src_a = 32'h0BAD_0BAD; ex_leave = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (hi !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mthi_noleave: got %h expected deadbeef", hi);
        end
        ex_valid = 1'b0; ex_mdu_op = 3'd0;
        #1;
    endtask

    task automatic test_mult();
        logic [2:0]  ops [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
        logic [31:0] va  [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] vb  [4] = '{32'h0000_0003, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] eh  [4] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFE};
        logic [31:0] el  [4] = '{32'hFFFF_FFFA, 32'hFFFF_FFFA, 32'h0000_0001, 32'h0000_0001};
        int n;
        logic [31:0] hi_before, lo_before;
        for (int i = 0; i < 4; i++) begin
            hi_before = hi; lo_before = lo;
            start_and_wait(ops[i], va[i], vb[i], n);
            checks++;
            if (n !== 2) begin
                errors++;
                $display("FAIL mult_stall[%0d]: got %0d cycles expected 2", i, n);
            end
            checks++;
            if (hi !== hi_before || lo !== lo_before) begin
                errors++;
                $display("FAIL mult_early[%0d]: hi=%h lo=%h expected %h %h", i, hi, lo, hi_before, lo_before);
            end
            leave_ex();
            checks++;
            if (hi !== eh[i] || lo !== el[i]) begin
                errors++;
                $display("FAIL mult_result[%0d]: hi=%h lo=%h expected %h %h", i, hi, lo, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [6] = '{3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd3};
        logic [31:0] va  [6] = '{32'hFFFF_FFF9, 32'd100, 32'h1234_5678, 32'h8000_0000, 32'h8000_0001, 32'd7};
        logic [31:0] vb  [6] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE};
        logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'd2, 32'h1234_5678, 32'd0, 32'h8000_0001, 32'd1};
        logic [31:0] el  [6] = '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        int n;
        for (int i = 0; i < 6; i++) begin
            start_and_wait(ops[i], va[i], vb[i], n);
            checks++;
            if (n !== 33) begin
                errors++;
                $display("FAIL div_stall[%0d]: got %0d cycles expected 33", i, n);
            end
            leave_ex();
            checks++;
            if (hi !== eh[i] || lo !== el[i]) begin
                errors++;
                $display("FAIL div_result[%0d]: hi=%h lo=%h expected %h %h", i, hi, lo, eh[i], el[i]);
            end
        end
    endtask

    task automatic test_flush();
        int n;
        ex_valid = 1'b1; ex_leave = 1'b1; ex_mdu_op = 3'd5; ex_src_a = 32'h5555_5555;
        @(posedge clk); #1;
        ex_mdu_op = 3'd6;
        @(posedge clk); #1;
        ex_leave = 1'b0;
        // Divide flushed in its tenth stall cycle.
        ex_mdu_op = 3'd3; ex_src_a = 32'd1000; ex_src_b = 32'd3;
        #1;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (div_mul_stall !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_prestall: stall=%b busy=%b expected 1 1", div_mul_stall, busy);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (div_mul_stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_drop: got %b expected 0", div_mul_stall);
        end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        // Back in IDLE: the still-present divide issues again immediately.
        checks++;
        if (busy !== 1'b0 || div_mul_stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: busy=%b stall=%b expected 0 1", busy, div_mul_stall);
        end
        flush = 1'b1;
        #1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_mdu_op = 3'd0;
        #1;
        checks++;
        if (hi !== 32'h5555_5555 || lo !== 32'h5555_5555 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_div_hilo: hi=%h lo=%h busy=%b expected 55555555 55555555 0", hi, lo, busy);
        end
        // Flush while the result waits in DONE.
        start_and_wait(3'd2, 32'd3, 32'd3, n);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_valid = 1'b0; ex_mdu_op = 3'd0;
        ex_leave = 1'b1;
        @(posedge clk); #1;
        ex_leave = 1'b0;
        #1;
        checks++;
        if (hi !== 32'h5555_5555 || lo !== 32'h5555_5555) begin
            errors++;
            $display("FAIL flush_done_hilo: hi=%h lo=%h expected 55555555 55555555", hi, lo);
        end
    endtask

    task automatic test_hold_in_done();
        int n;
        start_and_wait(3'd1, 32'd5, 32'd7, n);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (div_mul_stall !== 1'b0 || busy !== 1'b0 || hi !== 32'h5555_5555 || lo !== 32'h5555_5555) begin
                errors++;
                $display("FAIL hold_done[%0d]: stall=%b busy=%b hi=%h lo=%h expected 0 0 55555555 55555555",
                         c, div_mul_stall, busy, hi, lo);
            end
            @(posedge clk); #1;
        end
        leave_ex();
        checks++;
        if (hi !== 32'd0 || lo !== 32'd35) begin
            errors++;
            $display("FAIL hold_commit: hi=%h lo=%h expected 0 23", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        start_and_wait(3'd2, 32'h0001_0000, 32'h0001_0000, n);
        leave_ex();
        start_and_wait(3'd4, 32'd100, 32'd7, n);
        checks++;
        if (n !== 33 || hi !== 32'd1 || lo !== 32'd0) begin
            errors++;
            $display("FAIL b2b_first: cycles=%0d hi=%h lo=%h expected 33 1 0", n, hi, lo);
        end
        leave_ex();
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL b2b_second: hi=%h lo=%h expected 2 e", hi, lo);
        end
    endtask

    task automatic test_reset_mid_div();
        ex_valid = 1'b1; ex_mdu_op = 3'd3; ex_src_a = 32'd77; ex_src_b = 32'd5; ex_leave = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || div_mul_stall !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div: hi=%h lo=%h stall=%b busy=%b expected all zero", hi, lo, div_mul_stall, busy);
        end
        ex_valid = 1'b0; ex_mdu_op = 3'd0;
        @(posedge clk); #1;
        resetn = 1'b1;
        #1;
    endtask

    initial begin
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_div();
        test_flush();
        test_hold_in_done();
        test_back_to_back();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
